// File: rtl/fetch_redirect_unit.sv
// Fetch PC owner: sequential increment, taken-branch redirect, stall hold,
// deferred redirect while stalled, and multi-cycle IF/ID flush generation.
module fetch_redirect_unit #(
  parameter int               XLEN         = 32,
  parameter logic [XLEN-1:0]  RESET_PC     = 32'h0000_0000,
  parameter int               FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  input  logic            fetch_stall,
  output logic [XLEN-1:0] pc,
  output logic            pc_valid,
  output logic            flush_if,
  output logic            flush_id,
  output logic            redirect_pending,
  output logic            misalign_err
);

  typedef enum logic {RUN, PENDING} state_t;

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

  state_t          state, state_nxt;
  logic [2:0]      flush_cnt, flush_nxt;
  logic [XLEN-1:0] tgt_q, tgt_nxt, pc_nxt, aligned_tgt;
  logic            accept;

  function automatic logic [XLEN-1:0] align_target(input logic [XLEN-1:0] t);
    return {t[XLEN-1:2], 2'b00};
  endfunction

  // A branch arriving during flush or while a redirect waits is wrong-path.
  assign accept      = br_taken && (state == RUN) && (flush_cnt == 3'd0);
  assign aligned_tgt = align_target(br_target);
  assign flush_nxt   = accept ? FLUSH_LOAD
                     : ((flush_cnt != 3'd0) ? flush_cnt - 3'd1 : 3'd0);

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    tgt_nxt   = tgt_q;
    case (state)
      RUN: begin
        if (accept) begin
          if (fetch_stall) begin
            state_nxt = PENDING;
            tgt_nxt   = aligned_tgt;
          end else begin
            pc_nxt = aligned_tgt;
          end
        end else if (pc_valid && !fetch_stall) begin
          // RESET_PC itself is fetched once before the first increment.
          pc_nxt = pc + XLEN'(4);
        end
      end
      PENDING: begin
        if (!fetch_stall) begin
          pc_nxt    = tgt_q;
          state_nxt = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= RUN;
      flush_cnt        <= 3'd0;
      tgt_q            <= '0;
      pc               <= RESET_PC;
      pc_valid         <= 1'b0;
      flush_if         <= 1'b0;
      flush_id         <= 1'b0;
      redirect_pending <= 1'b0;
      misalign_err     <= 1'b0;
    end else begin
      state            <= state_nxt;
      flush_cnt        <= flush_nxt;
      tgt_q            <= tgt_nxt;
      pc               <= pc_nxt;
      pc_valid         <= 1'b1;
      flush_if         <= (flush_nxt != 3'd0);
      flush_id         <= (flush_nxt != 3'd0);
      redirect_pending <= (state_nxt == PENDING);
      misalign_err     <= accept && (br_target[1:0] != 2'b00);
    end
  end

endmodule

// File: doc/fetch_redirect_unit.md
Name: fetch_redirect_unit

Overview:
- Consumes the registered branch/jump decision (br_taken) and resolved target from execute.
- Owns the fetch PC register: sequential increment, redirect on taken branch/jump, hold on fetch stall.
- Generates multi-cycle flush pulses for IF/ID wrong-path squash and defers redirects that arrive while fetch is stalled (e.g. I-cache miss).

Parameters:
- XLEN, 32, PC and target width.
- RESET_PC, 32'h0000_0000, PC value loaded by reset.
- FLUSH_CYCLES, 2, cycles flush_if/flush_id stay high after a redirect is accepted; legal range 1..7.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- br_taken  input  1  registered taken-branch/jump indication from execute; valid for one cycle.
- br_target  input  XLEN  redirect target, valid when br_taken=1.
- fetch_stall  input  1  fetch cannot accept a new PC this cycle.
- pc  output  XLEN  current fetch PC, registered.
- pc_valid  output  1  pc is a valid fetch request, registered.
- flush_if  output  1  squash IF-stage instruction, registered.
- flush_id  output  1  squash ID-stage instruction, registered.
- redirect_pending  output  1  a redirect is latched and waiting for stall release.
- misalign_err  output  1  one-cycle pulse: accepted target had br_target[1:0]!=0.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-flush or mid-pending):
  - pc=RESET_PC, pc_valid=0, flush_if=flush_id=0, redirect_pending=0, misalign_err=0.
  - State=RUN, flush counter=0, pending target cleared.
- pc_valid goes to 1 on the first rising edge after reset deasserts and stays 1 thereafter.
- States: RUN, PENDING.
- Flush counter (width 3) runs independently of state. flush_if=flush_id=(counter!=0). Counter decrements by 1 per cycle to 0.
- br_taken is accepted only when state=RUN and flush counter=0. Otherwise it is ignored: it comes from a wrong-path instruction.
- RUN, no accepted br_taken:
  - fetch_stall=0: pc<=pc+4, modulo 2^XLEN (32'hFFFF_FFFC wraps to 0).
  - fetch_stall=1: pc holds.
- RUN, accepted br_taken, fetch_stall=0:
  - pc<={br_target[XLEN-1:2],2'b00} at the same edge.
  - Counter<=FLUSH_CYCLES, so flush is high for exactly FLUSH_CYCLES cycles starting the next cycle.
  - Latency br_taken to new pc visible: 1 edge.
- RUN, accepted br_taken, fetch_stall=1:
  - Latch aligned target, go to PENDING, set redirect_pending=1.
  - Counter<=FLUSH_CYCLES; flush starts immediately even though pc holds.
- PENDING:
  - pc holds while fetch_stall=1.
  - On the first edge with fetch_stall=0: pc<=latched target, redirect_pending<=0, state<=RUN.
  - No pc+4 occurs on that edge.
- misalign_err: asserted for 1 cycle on the edge after an accepted br_taken with br_target[1:0]!=0. The redirect still proceeds with bits [1:0] forced to 0. Ignored br_taken never raises misalign_err.
- Simultaneous events:
  - br_taken and fetch_stall in the same cycle: handled as the pending case above.
  - Counter expiring while PENDING: flush deasserts; pc stays held until the stall releases.
- Multi-cycle outputs are fully registered; no combinational path from inputs to outputs.

Test Plan:
- Reset release, fetch_stall=0, 4 cycles -> pc sequence 0,4,8,12; pc_valid=1 from the first edge after reset; flush=0 throughout.
- At pc=8, br_taken=1, br_target=32'h100, stall=0 -> next pc=32'h100, then 32'h104. flush_if/flush_id high exactly 2 cycles. redirect_pending=0.
- br_taken=1, target=32'h200 with fetch_stall=1 held 3 more cycles -> redirect_pending=1 and pc held for 3 cycles. Flush high 2 cycles starting at latch. On release, pc=32'h200 and redirect_pending=0.
- br_taken, target=32'h300 accepted; second br_taken, target=32'h400 one cycle later (counter!=0) -> second ignored; pc=32'h300 then 32'h304.
- Target 32'h102 -> pc=32'h100, misalign_err pulses for exactly 1 cycle. pc=32'hFFFF_FFFC with no branch -> next pc=0.
- Assert reset asynchronously mid-flush while PENDING -> outputs return to reset values immediately without waiting for a clock edge. After release the pc sequence restarts at RESET_PC.
